// File: rtl/bitrev_reorder.sv
// Ping-pong frame buffer: coefficients arrive in natural order and leave in bit-reversed order.
// Optional macro BITREV_FRAME_CNT_EN adds a 16-bit frame_cnt output counting drained frames.
module bitrev_reorder #(
    parameter int unsigned data_width = 12,
    parameter int unsigned log_n      = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
`ifdef BITREV_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt
`endif
);

    localparam int unsigned n = 1 << log_n;
    localparam logic [log_n-1:0] last_idx = '1;

    logic [data_width-1:0] mem [0:1][0:n-1];
    logic [1:0]            full;
    logic [1:0]            full_nxt;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [log_n-1:0]      wr_addr;
    logic [log_n-1:0]      rd_cnt;
    logic                  wr_fire;
    logic                  rd_fire;

    function automatic logic [log_n-1:0] bitrev(input logic [log_n-1:0] a);
        logic [log_n-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < log_n; i++) begin
            r[i] = a[log_n-1-i];
        end
        return r;
    endfunction

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign out_data  = mem[rd_bank][bitrev(rd_cnt)];
    assign out_last  = out_valid && (rd_cnt == last_idx);
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;

    // Set and clear always target different banks: a bank is written only while empty and read only while full.
    always_comb begin
        full_nxt = full;
        if (wr_fire && (wr_addr == last_idx)) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_fire && (rd_cnt == last_idx)) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_addr <= '0;
            rd_cnt  <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_addr <= wr_addr + 1'b1;
                if (wr_addr == last_idx) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == last_idx) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end

    // Storage is deliberately not reset; contents are only observable behind a full flag.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_addr] <= in_data;
        end
    end

`ifdef BITREV_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (rd_fire && out_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bitrev_reorder.sv
// Randomized self-checking bench for bitrev_reorder (log_n = 3) against a frame-queue reference model.
module tb_bitrev_reorder;

    localparam int DW   = 12;
    localparam int LOGN = 3;
    localparam int N    = 1 << LOGN;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
`ifdef BITREV_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    bitrev_reorder #(.data_width(DW), .log_n(LOGN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
`ifdef BITREV_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: completed frames waiting to drain, expected output stream, write position.
    int            pending = 0;
    int            wr_pos  = 0;
    int            rd_pos  = 0;
    int            drained = 0;
    int            acc     = 0;
    logic [DW-1:0] cur [N];
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rev(input int idx);
        int r = 0;
        int v = idx;
        for (int k = 0; k < LOGN; k++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic model_clear();
        pending = 0;
        wr_pos  = 0;
        rd_pos  = 0;
        drained = 0;
        exp_q.delete();
    endtask

    task automatic step(input bit iv, input logic [DW-1:0] d, input bit ordy);
        bit exp_rdy;
        bit exp_v;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_rdy = (pending < 2);
        exp_v   = (pending > 0);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(exp_v));
        if (exp_v) begin
            check("out_data", 32'(out_data), 32'(exp_q[0]));
            check("out_last", 32'(out_last), 32'(rd_pos == N - 1));
        end else begin
            check("out_last_idle", 32'(out_last), 32'd0);
        end
`ifdef BITREV_FRAME_CNT_EN
        check("frame_cnt", 32'(frame_cnt), 32'(drained % 65536));
`endif
        if (exp_v && ordy) begin
            void'(exp_q.pop_front());
            if (rd_pos == N - 1) begin
                rd_pos = 0;
                pending--;
                drained++;
            end else begin
                rd_pos++;
            end
        end
        if (iv && exp_rdy) begin
            acc++;
            cur[wr_pos] = d;
            if (wr_pos == N - 1) begin
                for (int j = 0; j < N; j++) exp_q.push_back(cur[rev(j)]);
                pending++;
                wr_pos = 0;
            end else begin
                wr_pos++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_last", 32'(out_last), 32'd0);
`ifdef BITREV_FRAME_CNT_EN
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_clear();
        do_reset();

        // Single frame 0..7, output 0,4,2,6,1,5,3,7 one cycle after the last write
        acc = 0;
        repeat (8) step(1'b1, DW'(acc), 1'b1);
        repeat (10) step(1'b0, '0, 1'b1);

        // Three continuous frames 0..23
        acc = 0;
        repeat (45) step(acc < 24, DW'(acc), 1'b1);

        // Fill both banks with downstream stalled, then release
        do_reset();
        acc = 0;
        repeat (20) step(1'b1, DW'(acc), 1'b0);
        repeat (35) step(acc < 24, DW'(acc), 1'b1);

        // Random downstream stalls within a frame
        do_reset();
        acc = 0;
        repeat (40) step(acc < 8, DW'(acc), 1'($urandom_range(0, 1)));
        repeat (20) step(1'b0, '0, 1'b1);

        // Reset with a partial frame, then with three outputs still pending
        do_reset();
        acc = 0;
        repeat (5) step(1'b1, DW'(acc), 1'b0);
        do_reset();
        acc = 0;
        repeat (8) step(1'b1, DW'(acc), 1'b0);
        repeat (5) step(1'b0, '0, 1'b1);
        do_reset();
        acc = 0;
        repeat (8) step(1'b1, DW'(acc + 8), 1'b1);
        repeat (12) step(1'b0, '0, 1'b1);

        // Long random traffic
        do_reset();
        repeat (800) step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0);
        repeat (40) step(1'b0, '0, 1'b1);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitrev_reorder.md
BITREV_REORDER -- requirements
Module: bitrev_reorder

Interface
REQ-001 SHALL have parameter data_width, default 12, coefficient width in bits.
REQ-002 SHALL have parameter log_n, default 9, log2 of frame length N (N = 2^log_n coefficients).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  data_width  coefficient, natural order.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port out_data  output  data_width  coefficient, bit-reversed order.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 SHALL have port out_last  output  1  high with the final coefficient of a frame.

Function
REQ-012 SHALL hold two banks (ping-pong) of N x data_width entries, each with one full flag.
REQ-013 SHALL write bank wr_bank at address wr_addr on each in_valid & in_ready cycle; wr_addr increments by 1.
REQ-014 SHALL, on a write with wr_addr = N-1: set full[wr_bank], toggle wr_bank, wrap wr_addr to 0.
REQ-015 SHALL drive in_ready = !full[wr_bank] (combinational from registered flags only, not from out_ready).
REQ-016 SHALL drive out_valid = full[rd_bank]; out_data = bank[rd_bank][bitrev(rd_cnt)], bitrev reversing all log_n bits; read asynchronous from array.
REQ-017 SHALL drive out_last = out_valid & (rd_cnt = N-1).
REQ-018 SHALL increment rd_cnt on out_valid & out_ready; on transfer with rd_cnt = N-1: clear full[rd_bank], toggle rd_bank, wrap rd_cnt to 0.
REQ-019 SHALL hold out_data, out_valid, out_last stable while out_valid & !out_ready.
REQ-020 SHALL assert out_valid the cycle after the frame's last input is accepted (latency 1 cycle from last write to first output) when rd_bank is idle.
REQ-021 SHALL sustain 1 coefficient/cycle in and out simultaneously once both banks are cycling, with no bubbles when in_valid and out_ready are held high.
REQ-022 SHALL, when the last read of bank X and a stalled write waiting on bank X coincide, raise in_ready the following cycle (no combinational ready path).
REQ-023 SHALL allow a write to one bank and a read of the other bank in the same cycle; same-bank write and read never coincide.
REQ-024 SHALL ignore in_data when in_valid & !in_ready; no state change.

Reset
REQ-025 SHALL, while rst = 0, clear both full flags, wr_bank, rd_bank, wr_addr, rd_cnt; out_valid = 0, out_last = 0, in_ready = 1.
REQ-026 SHALL NOT reset bank array contents; out_data is don't-care while out_valid = 0.
REQ-027 SHALL discard any partial or undrained frame on reset mid-operation; first post-reset input starts a new frame in bank 0.

Configuration
REQ-028 SHALL, with macro BITREV_FRAME_CNT_EN defined, add output frame_cnt (16 bits, reset 0) incrementing on every out_last transfer, wrapping 0xFFFF to 0.
REQ-029 SHALL, without BITREV_FRAME_CNT_EN, omit the frame_cnt port and counter; all other behaviour identical.

Verification (log_n = 3, data_width = 12)
REQ-030 Reset then write 0..7 back-to-back, out_ready = 1 -> out_data 0,4,2,6,1,5,3,7; out_last only on 7; out_valid rises 1 cycle after write of 7.
REQ-031 Stream 3 frames (values 0..23) continuously, in_valid = out_ready = 1 -> in_ready never drops after bank fill; output frames bit-reversed per frame with no gaps.
REQ-032 Write 16 values with out_ready = 0 -> in_ready drops after 16th write; 17th held; release out_ready -> in_ready rises 1 cycle after 8th read of bank 0.
REQ-033 Toggle out_ready randomly during a frame -> out_data/out_last stable during stalls; sequence still 0,4,2,6,1,5,3,7.
REQ-034 Assert rst after 5 writes and again with 3 outputs pending -> out_valid = 0, in_ready = 1 immediately; next frame 8..15 outputs 8,12,10,14,9,13,11,15.
REQ-035 With BITREV_FRAME_CNT_EN, drain 3 frames -> frame_cnt = 3; reset -> frame_cnt = 0.
